// File: rtl/mini_src_pkg.sv
// mini_src_pkg: shared opcodes, control-bit indices, step encodings and opcode classing for the Mini-SRC control unit
package mini_src_pkg;
  localparam int CTL_W = 20;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011,
                         OP_SHL = 5'b01011, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110,
                         OP_BR = 5'b10011, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam int CTL_GRA = 0, CTL_GRB = 1, CTL_GRC = 2, CTL_RIN = 3, CTL_ROUT = 4, CTL_BAOUT = 5,
                 CTL_COUT = 6, CTL_PCOUT = 7, CTL_PCIN = 8, CTL_INCPC = 9, CTL_MARIN = 10,
                 CTL_MDRIN = 11, CTL_MDROUT = 12, CTL_READ = 13, CTL_WRITE = 14, CTL_IRIN = 15,
                 CTL_YIN = 16, CTL_ZIN = 17, CTL_ZLOWOUT = 18, CTL_CONIN = 19;
  localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4, T5 = 4'd5,
                         T6 = 4'd6, T7 = 4'd7, S_RESET = 4'd14, S_HALT = 4'd15;
  typedef enum logic [2:0] {C_NOP, C_ALU, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_HALT} op_class_t;
  // Unlisted opcodes fall into C_NOP so they execute as a one-step no-op.
  function automatic op_class_t op_class(input logic [4:0] op);
    return (op >= OP_ADD && op <= OP_SHL) ? C_ALU :
           (op == OP_ADDI || op == OP_ANDI || op == OP_ORI) ? C_IMM :
           op == OP_LDI ? C_LDI : op == OP_LD ? C_LD : op == OP_ST ? C_ST :
           op == OP_BR ? C_BR : op == OP_HALT ? C_HALT : op == OP_NOP ? C_NOP : C_NOP;
  endfunction
  function automatic logic [CTL_W-1:0] bit_of(input int i);
    return CTL_W'(1) << i;
  endfunction
endpackage

// File: rtl/mini_src_ctl_decode.sv
// mini_src_ctl_decode: combinational step/opcode/CON_FF -> control strobes and ALU select
//   step[3:0] current step, op[4:0] opcode, con_ff branch condition
//   ctl[CTL_W-1:0] packed strobes, alu_control[4:0] ALU operation
module mini_src_ctl_decode
  import mini_src_pkg::*;
(
  input  logic [3:0]       step,
  input  logic [4:0]       op,
  input  logic             con_ff,
  output logic [CTL_W-1:0] ctl,
  output logic [4:0]       alu_control
);
  op_class_t c;
  assign c = op_class(op);
  always_comb begin
    ctl = '0;
    alu_control = '0;
    case (step)
      T0: ctl = bit_of(CTL_PCOUT) | bit_of(CTL_MARIN) | bit_of(CTL_INCPC) | bit_of(CTL_ZIN);
      T1: ctl = bit_of(CTL_ZLOWOUT) | bit_of(CTL_PCIN) | bit_of(CTL_READ) | bit_of(CTL_MDRIN);
      T2: ctl = bit_of(CTL_MDROUT) | bit_of(CTL_IRIN);
      T3: case (c)
        C_ALU, C_IMM:       ctl = bit_of(CTL_GRB) | bit_of(CTL_ROUT) | bit_of(CTL_YIN);
        C_LDI, C_LD, C_ST:  ctl = bit_of(CTL_GRB) | bit_of(CTL_BAOUT) | bit_of(CTL_YIN);
        C_BR:               ctl = bit_of(CTL_GRA) | bit_of(CTL_ROUT) | bit_of(CTL_CONIN);
        default: ;
      endcase
      T4: begin
        case (c)
          C_ALU:                    ctl = bit_of(CTL_GRC) | bit_of(CTL_ROUT) | bit_of(CTL_ZIN);
          C_IMM, C_LDI, C_LD, C_ST: ctl = bit_of(CTL_COUT) | bit_of(CTL_ZIN);
          C_BR:                     ctl = bit_of(CTL_PCOUT) | bit_of(CTL_YIN);
          default: ;
        endcase
        alu_control = (c == C_ALU || c == C_IMM) ? op :
                      (c == C_LDI || c == C_LD || c == C_ST) ? ALU_ADD : '0;
      end
      T5: case (c)
        C_ALU, C_IMM, C_LDI: ctl = bit_of(CTL_ZLOWOUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN);
        C_LD, C_ST:          ctl = bit_of(CTL_ZLOWOUT) | bit_of(CTL_MARIN);
        C_BR: begin
          ctl = bit_of(CTL_COUT) | bit_of(CTL_ZIN);
          alu_control = ALU_ADD;
        end
        default: ;
      endcase
      T6: case (c)
        C_LD: ctl = bit_of(CTL_READ) | bit_of(CTL_MDRIN);
        C_ST: ctl = bit_of(CTL_GRA) | bit_of(CTL_ROUT) | bit_of(CTL_MDRIN);
        C_BR: ctl = bit_of(CTL_ZLOWOUT) | (con_ff ? bit_of(CTL_PCIN) : '0);
        default: ;
      endcase
      T7: case (c)
        C_LD: ctl = bit_of(CTL_MDROUT) | bit_of(CTL_GRA) | bit_of(CTL_RIN);
        C_ST: ctl = bit_of(CTL_WRITE);
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: rtl/mini_src_control_unit.sv
// mini_src_control_unit: Mini-SRC control sequencer (fetch, decode, T0..T7 steps, memory wait, halt/fault)
//   clock, clear (async active-low), IR[31:0], CON_FF, mem_ready, Stop
//   ctl[19:0] strobes, ALU_Control[4:0], Run, mem_err (sticky timeout), step[3:0] debug
module mini_src_control_unit
  import mini_src_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             CON_FF,
  input  logic             mem_ready,
  input  logic             Stop,
  output logic [CTL_W-1:0] ctl,
  output logic [4:0]       ALU_Control,
  output logic             Run,
  output logic             mem_err,
  output logic [3:0]       step
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);
  logic [4:0] op;
  op_class_t c;
  logic wait_step, timeout, unused_ir;
  logic [CW-1:0] wcnt;
  logic [3:0] nxt;
  assign op = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign c = op_class(op);
  assign wait_step = step == T1 || (step == T6 && c == C_LD) || (step == T7 && c == C_ST);
  // wcnt counts wait cycles already spent; the last allowed cycle without mem_ready faults.
  assign timeout = wait_step && !mem_ready && wcnt == CW'(WAIT_LIMIT - 1);
  assign Run = step != S_RESET && step != S_HALT;
  always_comb begin
    nxt = S_HALT;
    case (step)
      S_RESET: nxt = T0;
      T0:      nxt = T1;
      T1:      nxt = mem_ready ? T2 : T1;
      T2:      nxt = Stop ? S_HALT : T3;
      T3:      nxt = c == C_HALT ? S_HALT : c == C_NOP ? T0 : T4;
      T4:      nxt = T5;
      T5:      nxt = (c == C_LD || c == C_ST || c == C_BR) ? T6 : T0;
      T6:      nxt = c == C_BR ? T0 : (c == C_ST || mem_ready) ? T7 : T6;
      T7:      nxt = (c == C_ST && !mem_ready) ? T7 : T0;
      default: nxt = S_HALT;
    endcase
    nxt = timeout ? S_HALT : nxt;
  end
  always_ff @(posedge clock or negedge clear)
    if (!clear) begin
      step    <= S_RESET;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      step    <= nxt;
      wcnt    <= (wait_step && !mem_ready && !timeout) ? wcnt + CW'(1) : '0;
      mem_err <= mem_err | timeout;
    end
  mini_src_ctl_decode u_dec (
    .step        (step),
    .op          (op),
    .con_ff      (CON_FF),
    .ctl         (ctl),
    .alu_control (ALU_Control)
  );
endmodule
